// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit: iterative shift-add multiply and restoring divide into MIPS HI/LO.
// Define MULDIV_SIGNED_EN to build the signed MULT/DIV path (op[0]); otherwise every op is unsigned.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             state;
    logic [CW-1:0]      counter;
    logic               is_div;
    logic               dz;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] acc_init;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   opnd_init;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               dz_in;
    logic               accept;

    // The cycle after done still reports busy, so a new request is taken only once busy has dropped.
    assign accept = (state == S_IDLE) && !busy && start;
    assign dz_in  = op[1] && (operand_b == '0);

`ifdef MULDIV_SIGNED_EN
    logic neg_res;
    logic neg_rem;
    logic sgn_in;
    logic neg_res_in;
    logic neg_rem_in;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + (2*WIDTH)'(1);
    endfunction

    assign sgn_in     = op[0];
    assign a_mag      = (sgn_in && operand_a[WIDTH-1]) ? neg_w(operand_a) : operand_a;
    assign b_mag      = (sgn_in && operand_b[WIDTH-1]) ? neg_w(operand_b) : operand_b;
    assign neg_res_in = sgn_in && !dz_in && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
    assign neg_rem_in = sgn_in && !dz_in && operand_a[WIDTH-1];

    always_comb begin
        fix_hi = acc[2*WIDTH-1:WIDTH];
        fix_lo = acc[WIDTH-1:0];
        if (is_div) begin
            if (neg_res) fix_lo = neg_w(acc[WIDTH-1:0]);
            if (neg_rem) fix_hi = neg_w(acc[2*WIDTH-1:WIDTH]);
        end else if (neg_res) begin
            {fix_hi, fix_lo} = neg_2w(acc);
        end
    end
`else
    logic unused_op0;

    assign unused_op0 = op[0];
    assign a_mag      = operand_a;
    assign b_mag      = operand_b;
    assign fix_hi     = acc[2*WIDTH-1:WIDTH];
    assign fix_lo     = acc[WIDTH-1:0];
`endif

    // Divide-by-zero preloads the final {hi,lo} so FIX only has to copy it out.
    always_comb begin
        if (dz_in)
            acc_init = {operand_a, {WIDTH{1'b1}}};
        else if (op[1])
            acc_init = {{WIDTH{1'b0}}, a_mag};
        else
            acc_init = {{WIDTH{1'b0}}, b_mag};
        opnd_init = op[1] ? b_mag : a_mag;
    end

    // acc = {partial product, multiplier} for multiply, {remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd & {WIDTH{acc[0]}}};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (is_div)
            acc_step = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                        acc[WIDTH-2:0], ~div_diff[WIDTH]};
        else
            acc_step = {mul_sum, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            acc  <= acc_init;
            opnd <= opnd_init;
        end else if (state == S_RUN) begin
            acc  <= acc_step;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            counter     <= '0;
            is_div      <= 1'b0;
            dz          <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        busy    <= 1'b1;
                        is_div  <= op[1];
                        dz      <= dz_in;
                        counter <= CW'(WIDTH - 1);
                        state   <= dz_in ? S_FIX : S_RUN;
`ifdef MULDIV_SIGNED_EN
                        neg_res <= neg_res_in;
                        neg_rem <= neg_rem_in;
`endif
                    end else begin
                        busy <= 1'b0;
                        if (!busy && hi_we) hi <= wdata;
                        if (!busy && lo_we) lo <= wdata;
                    end
                end
                S_RUN: begin
                    if (counter == '0)
                        state <= S_FIX;
                    else
                        counter <= counter - 1'b1;
                end
                S_FIX: begin
                    hi          <= fix_hi;
                    lo          <= fix_lo;
                    div_by_zero <= dz;
                    done        <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model with per-cycle compare plus directed literal checks.
module tb_mult_div_unit;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_pass = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endfunction

    // Expected result straight from the arithmetic definition of each op.
    function automatic void ref_result(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                       output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rd);
        bit          sgn;
        logic [63:0] p;
        longint      sa, sb, q, r;
`ifdef MULDIV_SIGNED_EN
        sgn = o[0];
`else
        sgn = 1'b0;
`endif
        rd = 1'b0;
        if (o[1] && b == '0) begin
            rd = 1'b1;
            rh = a;
            rl = '1;
        end else if (!o[1]) begin
            if (sgn) begin
                sa = $signed(a);
                sb = $signed(b);
                p = sa * sb;
            end else begin
                p = {32'b0, a} * {32'b0, b};
            end
            rh = p[63:32];
            rl = p[31:0];
        end else begin
            if (sgn) begin
                sa = $signed(a);
                sb = $signed(b);
                q = sa / sb;
                r = sa % sb;
                rl = q[31:0];
                rh = r[31:0];
            end else begin
                rl = a / b;
                rh = a % b;
            end
        end
    endfunction

    // Cycle model: latency countdown, pending result, HI/LO and busy/done expectations.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic         m_was_done = 1'b0;
    logic         m_dbz = 1'b0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] p_hi = '0;
    logic [W-1:0] p_lo = '0;
    logic         p_dz = 1'b0;
    int           left = 0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_hi = '0;
            m_lo = '0;
            m_dbz = 1'b0;
            left = 0;
        end else begin
            m_was_done = m_done;
            m_done = 1'b0;
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                    m_dbz = p_dz;
                    m_done = 1'b1;
                end
            end else if (m_was_done) begin
                m_busy = 1'b0;
            end else if (!m_busy) begin
                if (start) begin
                    ref_result(op, operand_a, operand_b, p_hi, p_lo, p_dz);
                    left = p_dz ? 1 : W + 1;
                    m_busy = 1'b1;
                end else begin
                    if (hi_we) m_hi = wdata;
                    if (lo_we) m_lo = wdata;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            chk("cyc_busy", busy, m_busy);
            chk("cyc_done", done, m_done);
            chk("cyc_hi", hi, m_hi);
            chk("cyc_lo", lo, m_lo);
            chk("cyc_dbz", div_by_zero, m_dbz);
        end
    end

    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit with_hiwe, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input logic ed, input int elat);
        int lat;
        bit found;
        @(posedge clock); #2;
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        hi_we = with_hiwe; wdata = 32'hDEAD_BEEF;
        @(posedge clock); #2;
        start = 1'b0; hi_we = 1'b0;
        lat = 0;
        found = 1'b0;
        while (!found && lat < 100) begin
            @(negedge clock);
            if (done) found = 1'b1;
            else lat++;
        end
        chk({name, "_latency"}, lat, elat);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
        chk({name, "_dbz"}, div_by_zero, ed);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nd;
        logic [W-1:0] rh, rl;

        repeat (3) @(posedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_dbz", div_by_zero, 1'b0);

        // MTHI / MTLO in idle
        @(posedge clock); #2;
        hi_we = 1'b1; wdata = 32'h1234_5678;
        @(posedge clock); #2;
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'hAABB_CCDD;
        @(posedge clock); #2;
        lo_we = 1'b0;
        @(negedge clock);
        chk("mthi", hi, 32'h1234_5678);
        chk("mtlo", lo, 32'hAABB_CCDD);

        run_op("multu_spec", 2'b00, 32'h0000_FFFF, 32'h0001_0000, 1'b0, 32'h0, 32'hFFFF_0000, 1'b0, W + 1);
        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, W + 1);
`ifdef MULDIV_SIGNED_EN
        run_op("mult_neg", 2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, W + 1);
        run_op("mult_negneg", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h1, 1'b0, W + 1);
        run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, W + 1);
        run_op("div_negdiv", 2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 32'h1, 32'hFFFF_FFFD, 1'b0, W + 1);
        run_op("div_minneg", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000, 1'b0, W + 1);
`else
        run_op("mult_neg", 2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0, W + 1);
        run_op("mult_negneg", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h1, 1'b0, W + 1);
        run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0, W + 1);
        run_op("div_negdiv", 2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 32'h7, 32'h0, 1'b0, W + 1);
        run_op("div_minneg", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'h0, 1'b0, W + 1);
`endif
        run_op("divu", 2'b10, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0, W + 1);
        run_op("divu_zero", 2'b10, 32'h0000_0064, 32'h0, 1'b0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1);
        run_op("div_zero", 2'b11, 32'hFFFF_FFF9, 32'h0, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 1);
        // start and MTHI together in idle: the write is dropped
        run_op("start_wins", 2'b00, 32'd3, 32'd5, 1'b1, 32'h0, 32'h0000_000F, 1'b0, W + 1);

        // start and MTHI while busy are both ignored
        @(posedge clock); #2;
        start = 1'b1; op = 2'b00; operand_a = 32'd7; operand_b = 32'd6;
        @(posedge clock); #2;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        start = 1'b1; operand_a = 32'd100; operand_b = 32'd100; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clock); #2;
        start = 1'b0; hi_we = 1'b0;
        nd = 0;
        rh = '0;
        rl = '0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clock);
            if (done) begin
                nd++;
                rh = hi;
                rl = lo;
            end
        end
        chk("busy_ignore_done_count", nd, 1);
        chk("busy_ignore_hi", rh, 32'h0);
        chk("busy_ignore_lo", rl, 32'h0000_002A);
        chk("busy_ignore_hi_after", hi, 32'h0);

        // reset mid-operation aborts without a done
        @(posedge clock); #2;
        start = 1'b1; op = 2'b00; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF;
        @(posedge clock); #2;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        @(posedge clock); #2;
        reset_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) nd++;
        end
        chk("abort_no_done", nd, 0);
        run_op("after_abort", 2'b00, 32'd3, 32'd5, 1'b0, 32'h0, 32'h0000_000F, 1'b0, W + 1);

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
